// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory block.
//
// Contents:
//   apb_cmp_state_e  completer transfer FSM states
//   APB_ID_VALUE     contents of the read-only identification word (word 0)
//   APB_DEF_DEPTH    default number of words in the register bank
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_cmp_state_e;

  localparam logic [31:0] APB_ID_VALUE  = 32'hA9B0_0001;
  localparam int          APB_DEF_DEPTH = 16;

endpackage

// File: rtl/apb_completer_regbank.sv
// Word storage behind the APB completer.
//
// Ports:
//   clk_i    clock, all writes on posedge
//   rst_ni   async active-low reset, clears every word
//   we_i     write enable for the word selected by idx_i
//   idx_i    word index shared by the read and write ports
//   wdata_i  write data
//   strb_i   byte lane enables; lanes with a 0 strobe keep their old value
//   rdata_o  combinational read of the word at idx_i
module apb_completer_regbank #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     strb_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-granular write port; the top only raises we_i for legal indices.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer backed by a word-addressed register bank with a read-only
// ID word at index 0, programmable wait states and error signalling.
//
// Ports:
//   pclk, presetn       clock and async active-low reset
//   psel, penable       APB select and access-phase qualifiers
//   pwrite, paddr       direction and byte address
//   pwdata, pstrb       write data and byte lane strobes
//   ws_cfg              wait states for the transfer, sampled at the setup edge
//   pready              registered transfer-complete flag
//   prdata              registered read data, 0 for writes and errors
//   pslverr             registered error flag, meaningful while pready is high
//
// DATA_WIDTH must be at least 16 so that the alignment bits are non-empty.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = APB_DEF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(APB_ID_VALUE)
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [3:0]              ws_cfg,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  apb_cmp_state_e        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [IDX_W-1:0]      decIdx, selIdx;
  logic                  decErr, selErr, selWrite;
  logic [DATA_WIDTH-1:0] bankRdata, loadData;
  logic                  bankWe;

  // Decode of the live bus address; only meaningful at the setup edge.
  assign wordAddr = paddr >> LSB;
  assign decIdx   = wordAddr[IDX_W-1:0];
  assign decErr   = (wordAddr >= ADDR_WIDTH'(DEPTH)) ||
                    (paddr[LSB-1:0] != '0) ||
                    (pwrite && (wordAddr == '0));

  // With zero wait states READY is entered straight from the setup edge, before
  // the transfer attributes are latched, so the response is built from the live
  // decode in IDLE and from the latched copy otherwise.
  assign selIdx   = (state_q == IDLE) ? decIdx : idx_q;
  assign selErr   = (state_q == IDLE) ? decErr : err_q;
  assign selWrite = (state_q == IDLE) ? pwrite : write_q;
  assign loadData = (selErr || selWrite) ? '0 :
                    (selIdx == '0)       ? ID_VALUE : bankRdata;

  apb_completer_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regbank (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .we_i    (bankWe),
    .idx_i   (selIdx),
    .wdata_i (wdata_q),
    .strb_i  (strb_q),
    .rdata_o (bankRdata)
  );

  // Transfer FSM. Responses are registered on entry to READY; any exit from
  // READY or WAIT returns the outputs to zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    bankWe    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          idx_d   = decIdx;
          err_d   = decErr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = ws_cfg;
          if (ws_cfg == 4'd0) begin
            state_d   = READY;
            pready_d  = 1'b1;
            prdata_d  = loadData;
            pslverr_d = decErr;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = READY;
            pready_d  = 1'b1;
            prdata_d  = loadData;
            pslverr_d = err_q;
          end
        end
      end

      READY: begin
        if (!psel || penable) begin
          // Commit only on a genuine completion; a dropped psel discards it.
          bankWe    = psel && write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Self-checking bench for apb_completer_mem: directed vector table, hand-written
// abort/reset sequences and randomized back-to-back write/read pairs checked
// against a simple array model of the bank.
module tb_apb_completer_mem;

  localparam int          DEPTH   = 16;
  localparam logic [31:0] ID_WORD = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb, ws_cfg;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mdlBank [DEPTH];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  ws;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs [17];

  always #5 pclk = ~pclk;

  apb_completer_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .ID_VALUE   (ID_WORD)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .ws_cfg  (ws_cfg),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr)
  );

  // Hard stop so a stuck simulation still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: bank as a plain array, rules written from the address map.
  function automatic bit mdlErr(input logic [31:0] addr, input bit wr);
    longint unsigned idx = longint'(addr) / 4;
    return (addr % 4 != 0) || (idx >= DEPTH) || (wr && idx == 0);
  endfunction

  function automatic logic [31:0] mdlRead(input logic [31:0] addr);
    if (mdlErr(addr, 1'b0)) return 32'h0;
    if (addr / 4 == 0) return ID_WORD;
    return mdlBank[addr / 4];
  endfunction

  task automatic mdlWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (!mdlErr(addr, 1'b1)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdlBank[addr / 4][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic mdlReset();
    for (int i = 0; i < DEPTH; i++) mdlBank[i] = 32'h0;
  endtask

  // One APB transfer. Returns with psel/penable still high in the pready cycle,
  // so the next call's setup lands in the cycle right after completion.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [3:0] ws,
                               output logic [31:0] rdata, output logic err, output int waits);
    bit timedOut;
    @(posedge pclk); #1;
    checkOutput("pready_low_at_setup", {31'b0, pready}, 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; ws_cfg = ws;
    @(posedge pclk); #1;
    penable = 1'b1;
    ws_cfg  = 4'($urandom);
    waits = 0; timedOut = 1'b0;
    while (!pready && !timedOut) begin
      waits++;
      if (waits > 40) timedOut = 1'b1;
      else begin @(posedge pclk); #1; end
    end
    rdata = prdata;
    err   = pslverr;
    if (timedOut) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL pready_timeout: got no pready after %0d cycles, expected %0d", waits, ws);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic runXfer(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input logic [3:0] ws,
                         input logic [31:0] expData, input bit expErr);
    logic [31:0] rd;
    logic        er;
    int          waits;
    applyStimulus(wr, addr, data, strb, ws, rd, er, waits);
    checkOutput({name, "_prdata"}, rd, expData);
    checkOutput({name, "_pslverr"}, {31'b0, er}, {31'b0, expErr});
    checkOutput({name, "_waits"}, 32'(waits), 32'(ws));
  endtask

  task automatic idleBus();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          sawReady;

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; ws_cfg = '0;
    mdlReset();
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("reset_pready", {31'b0, pready}, 32'h0);
    checkOutput("reset_prdata", prdata, 32'h0);
    checkOutput("reset_pslverr", {31'b0, pslverr}, 32'h0);
    @(negedge pclk) presetn = 1'b1;

    // Directed vectors, applied back-to-back.
    vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 4'd0,  32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd3,  32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 4'd1,  32'h0,        1'b0};
    vecs[4]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 4'd2,  32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 4'd0,  32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 4'd0,  32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 4'd1,  32'hA9B00001, 1'b0};
    vecs[8]  = '{1'b0, 32'h40, 32'h0,        4'h0, 4'd0,  32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h05, 32'hFFFFFFFF, 4'hF, 4'd0,  32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 32'h3C, 32'h0,        4'h0, 4'd15, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'h8, 4'd0,  32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'h0, 4'd0,  32'hCA000000, 1'b0};
    vecs[14] = '{1'b1, 32'h04, 32'h00000000, 4'h0, 4'd0,  32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 1'b0};
    vecs[16] = '{1'b0, 32'h02, 32'h0,        4'h0, 4'd0,  32'h0,        1'b1};

    for (int i = 0; i < 17; i++) begin
      runXfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].strb, vecs[i].ws, vecs[i].expData, vecs[i].expErr);
      if (vecs[i].wr) mdlWrite(vecs[i].addr, vecs[i].data, vecs[i].strb);
    end

    // psel dropped in the second wait cycle of a 5-wait-state write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h55555555; pstrb = 4'hF; ws_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    sawReady = pready;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sawReady |= pready;
      @(posedge pclk); #1;
    end
    checkOutput("abort_no_pready", {31'b0, sawReady}, 32'h0);
    runXfer("abort_read0C", 1'b0, 32'h0C, 32'h0, 4'h0, 4'd0, mdlRead(32'h0C), 1'b0);

    // Reset pulse while waiting: outputs clear and the write is lost.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h77777777; pstrb = 4'hF; ws_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    presetn = 1'b0;
    #1;
    checkOutput("rstwait_pready", {31'b0, pready}, 32'h0);
    checkOutput("rstwait_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    mdlReset();
    @(negedge pclk) presetn = 1'b1;
    runXfer("rstwait_read0C", 1'b0, 32'h0C, 32'h0, 4'h0, 4'd0, mdlRead(32'h0C), 1'b0);
    runXfer("rstwait_read04", 1'b0, 32'h04, 32'h0, 4'h0, 4'd1, mdlRead(32'h04), 1'b0);

    // Reset pulse while presenting ID data: outputs must clear before any edge.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00; ws_cfg = 4'd0;
    @(posedge pclk); #1;
    penable = 1'b1;
    checkOutput("rstready_before_prdata", prdata, ID_WORD);
    #2;
    presetn = 1'b0;
    #1;
    checkOutput("rstready_pready", {31'b0, pready}, 32'h0);
    checkOutput("rstready_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    mdlReset();
    @(negedge pclk) presetn = 1'b1;

    // Randomized back-to-back write/read pairs against the model.
    for (int p = 0; p < 8; p++) begin
      a = 32'($urandom_range(0, 17)) * 4;
      if ($urandom_range(0, 5) == 0) a = a + 32'd1;
      d = $urandom;
      s = 4'($urandom);
      runXfer($sformatf("rnd%0d_wr", p), 1'b1, a, d, s, 4'($urandom_range(0, 7)),
              32'h0, mdlErr(a, 1'b1));
      mdlWrite(a, d, s);
      runXfer($sformatf("rnd%0d_rd", p), 1'b0, a, 32'h0, 4'h0, 4'($urandom_range(0, 7)),
              mdlRead(a), mdlErr(a, 1'b0));
    end
    idleBus();
    @(posedge pclk); #1;
    checkOutput("final_pready", {31'b0, pready}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
